// File: rtl/ifetch_stage_if.sv
// ifetch_stage_if: instruction-memory request/ready bus between fetch and imem
interface ifetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
    modport slave (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/ifetch_stage.sv
// ifetch_stage: PC, imem handshake, redirects and the IF/ID pipeline register
module ifetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    ifetch_stage_if.master         io_imem,
    input  logic                   i_stall,
    input  logic                   i_branch_taken,
    input  logic [31:0]            i_branch_target,
    input  logic                   i_jump,
    input  logic [31:0]            i_jump_target,
    output logic                   o_if_valid,
    output logic [31:0]            o_if_instr,
    output logic [31:0]            o_if_pc4,
    output logic [5:0]             o_opcode
);
    typedef enum logic [1:0] {S_RUN, S_WAIT, S_HOLD, S_DRAIN} state_t;
    state_t      r_state, w_nstate;
    logic [31:0] r_pc, w_npc, r_if_instr, w_ninstr, r_if_pc4, w_npc4;
    logic [31:0] r_skid_instr, w_nskid_instr, r_skid_pc4, w_nskid_pc4, r_pend, w_npend;
    logic        r_if_valid, w_nvalid;
    logic        w_busy, w_req, w_redirect;
    logic [31:0] w_target, w_pc_inc;
    assign w_busy     = i_stall & r_if_valid;
    assign w_redirect = i_branch_taken | i_jump;
    assign w_target   = i_branch_taken ? i_branch_target : i_jump_target;
    assign w_pc_inc   = r_pc + PC_INC;
    assign w_req      = !i_reset & ((r_state == S_WAIT) | (r_state == S_DRAIN) | ((r_state == S_RUN) & !w_busy));
    assign io_imem.imem_req  = w_req;
    assign io_imem.imem_addr = r_pc;
    assign o_if_valid = r_if_valid;
    assign o_if_instr = r_if_instr;
    assign o_if_pc4   = r_if_pc4;
    assign o_opcode   = r_if_instr[31:26];
    // next-state: redirect squashes first, otherwise the per-state fetch/skid rules apply
    always_comb begin
        w_nstate      = r_state;
        w_npc         = r_pc;
        w_nvalid      = r_if_valid & i_stall;
        w_ninstr      = r_if_instr;
        w_npc4        = r_if_pc4;
        w_nskid_instr = r_skid_instr;
        w_nskid_pc4   = r_skid_pc4;
        w_npend       = r_pend;
        if (w_redirect) begin
            w_nvalid = 1'b0;
            if (w_req & !io_imem.imem_ready) begin
                w_npend  = w_target;
                w_nstate = S_DRAIN;
            end else begin
                w_npc    = w_target;
                w_nstate = S_RUN;
            end
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_req & io_imem.imem_ready) begin
                        w_ninstr = io_imem.imem_rdata;
                        w_npc4   = w_pc_inc;
                        w_nvalid = 1'b1;
                        w_npc    = w_pc_inc;
                    end else if (w_req) begin
                        w_nstate = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (io_imem.imem_ready) begin
                        w_npc = w_pc_inc;
                        if (w_busy) begin
                            w_nskid_instr = io_imem.imem_rdata;
                            w_nskid_pc4   = w_pc_inc;
                            w_nstate      = S_HOLD;
                        end else begin
                            w_ninstr = io_imem.imem_rdata;
                            w_npc4   = w_pc_inc;
                            w_nvalid = 1'b1;
                            w_nstate = S_RUN;
                        end
                    end
                end
                S_HOLD: begin
                    if (!w_busy) begin
                        w_ninstr = r_skid_instr;
                        w_npc4   = r_skid_pc4;
                        w_nvalid = 1'b1;
                        w_nstate = S_RUN;
                    end
                end
                S_DRAIN: begin
                    if (io_imem.imem_ready) begin
                        w_npc    = r_pend;
                        w_nstate = S_RUN;
                    end
                end
            endcase
        end
    end
    // state register with synchronous reset
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= S_RUN;
            r_pc         <= RESET_PC;
            r_if_valid   <= 1'b0;
            r_if_instr   <= '0;
            r_if_pc4     <= '0;
            r_skid_instr <= '0;
            r_skid_pc4   <= '0;
            r_pend       <= '0;
        end else begin
            r_state      <= w_nstate;
            r_pc         <= w_npc;
            r_if_valid   <= w_nvalid;
            r_if_instr   <= w_ninstr;
            r_if_pc4     <= w_npc4;
            r_skid_instr <= w_nskid_instr;
            r_skid_pc4   <= w_nskid_pc4;
            r_pend       <= w_npend;
        end
    end
endmodule

// File: tb/tb_ifetch_stage.sv
// tb_ifetch_stage: randomized fetch traffic checked against a program-order scoreboard
module tb_ifetch_stage;
    logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, br = 1'b0, jp = 1'b0;
    logic [31:0] bt = '0, jt = '0;
    logic        v, v2;
    logic [31:0] instr, pc4, instr2, pc42;
    logic [5:0]  opc, opc2;
    int          checks = 0, fails = 0, consumed = 0;
    logic [31:0] exp_q[$];
    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = '0;

    ifetch_stage_if imem();
    ifetch_stage_if imem2();

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ {a[7:2], 26'h15A5A5};
    endfunction

    assign imem.imem_rdata  = word_of(imem.imem_addr);
    assign imem2.imem_rdata = word_of(imem2.imem_addr);
    assign imem2.imem_ready = 1'b1;

    ifetch_stage dut (
        .i_clock(clk), .i_reset(rst), .io_imem(imem), .i_stall(stall),
        .i_branch_taken(br), .i_branch_target(bt), .i_jump(jp), .i_jump_target(jt),
        .o_if_valid(v), .o_if_instr(instr), .o_if_pc4(pc4), .o_opcode(opc));

    ifetch_stage #(.RESET_PC(32'hFFFFFFFC)) dut2 (
        .i_clock(clk), .i_reset(rst), .io_imem(imem2), .i_stall(1'b0),
        .i_branch_taken(1'b0), .i_branch_target(32'h0), .i_jump(1'b0), .i_jump_target(32'h0),
        .o_if_valid(v2), .o_if_instr(instr2), .o_if_pc4(pc42), .o_opcode(opc2));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    task automatic drive(input bit rdy, input bit st, input bit b, input logic [31:0] btg,
                         input bit j, input logic [31:0] jtg);
        @(posedge clk);
        #1;
        imem.imem_ready = rdy;
        stall = st;
        br = b;
        bt = btg;
        jp = j;
        jt = jtg;
        if (b | j) begin
            exp_q.delete();
            exp_q.push_back(b ? btg : jtg);
        end
    endtask

    task automatic rand_phase(input int n, input int rpct, input int spct, input int dpct);
        for (int i = 0; i < n; i++)
            drive($urandom_range(0, 99) < rpct, $urandom_range(0, 99) < spct,
                  $urandom_range(0, 99) < dpct, $urandom_range(0, 255) << 2,
                  $urandom_range(0, 99) < dpct, ($urandom_range(0, 255) << 2) | 32'h400);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        br = 1'b0;
        jp = 1'b0;
        stall = 1'b0;
        exp_q.delete();
        exp_q.push_back(32'h0);
    endtask

    // scoreboard monitor: every instruction decode accepts must be the next one in program order
    initial forever begin
        logic [31:0] a;
        @(negedge clk);
        if (rst) begin
            prev_pend = 1'b0;
        end else begin
            if (prev_pend) begin
                chk("req_held", {31'b0, imem.imem_req}, 32'h1);
                chk("addr_held", imem.imem_addr, prev_addr);
            end
            prev_pend = imem.imem_req & !imem.imem_ready;
            prev_addr = imem.imem_addr;
            if (v & !stall & !(br | jp)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL sb_empty: got instr %h with no expectation", instr);
                end else begin
                    a = exp_q.pop_front();
                    chk("sb_instr", instr, word_of(a));
                    chk("sb_pc4", pc4, a + 32'd4);
                    chk("sb_opcode", {26'b0, opc}, word_of(a) >> 26);
                    exp_q.push_back(a + 32'd4);
                    consumed++;
                end
            end
        end
    end

    initial begin
        imem.imem_ready = 1'b1;
        exp_q.push_back(32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'b0, imem.imem_req}, 32'h0);
        chk("rst_valid", {31'b0, v}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc4", pc4, 32'h0);
        chk("rst_opcode", {26'b0, opc}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("seq_req", {31'b0, imem.imem_req}, 32'h1);
            chk("seq_addr", imem.imem_addr, 32'(i * 4));
            if (i > 0) begin
                chk("seq_pc4", pc4, 32'(i * 4));
                chk("seq_opcode", {26'b0, opc}, word_of(32'((i - 1) * 4)) >> 26);
            end
            if (i == 0) chk("wrap_addr0", imem2.imem_addr, 32'hFFFFFFFC);
            if (i == 1) begin
                chk("wrap_addr1", imem2.imem_addr, 32'h0);
                chk("wrap_pc4", pc42, 32'h0);
            end
            if (i == 2) chk("wrap_pc4b", pc42, 32'h4);
        end
        // jump then branch while draining: the newest redirect must win
        drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b0, 0, 1'b1, 32'h40);
        drive(1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 0);
        drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
        @(negedge clk);
        chk("drain_done_req", {31'b0, imem.imem_req}, 32'h1);
        drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
        @(negedge clk);
        chk("drain_addr", imem.imem_addr, 32'h80);
        rand_phase(400, 100, 0, 0);
        rand_phase(400, 40, 0, 0);
        rand_phase(400, 50, 40, 0);
        rand_phase(400, 60, 30, 10);
        rand_phase(400, 30, 50, 20);
        rand_phase(400, 100, 20, 15);
        // reset while a request is waiting on memory
        repeat (3) drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
        repeat (2) drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
        @(negedge clk);
        chk("wait_req", {31'b0, imem.imem_req}, 32'h1);
        do_reset();
        @(negedge clk);
        chk("midrst_req", {31'b0, imem.imem_req}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_req", {31'b0, imem.imem_req}, 32'h1);
        chk("postrst_addr", imem.imem_addr, 32'h0);
        chk("postrst_valid", {31'b0, v}, 32'h0);
        rand_phase(300, 70, 30, 5);
        drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
        @(negedge clk);
        checks++;
        if (consumed < 300) begin
            fails++;
            $display("FAIL throughput: got %0d instructions consumed expected at least 300", consumed);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
